// File: rtl/melody_sequencer_pkg.sv
// Shared definitions for the melody sequencer: FSM encodings, ROM entry layout,
// note pitch codes and the default song table.
package melody_sequencer_pkg;

  localparam int HP_W    = 7;
  localparam int DUR_W   = 4;
  localparam int ENTRY_W = HP_W + DUR_W;

  localparam logic [DUR_W-1:0] DUR_END = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_FETCH = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Half-period codes: a smaller code gives a higher pitch.
  localparam logic [HP_W-1:0] NOTE_C4 = 7'd120;
  localparam logic [HP_W-1:0] NOTE_E4 = 7'd95;
  localparam logic [HP_W-1:0] NOTE_G4 = 7'd80;
  localparam logic [HP_W-1:0] NOTE_C5 = 7'd60;
  localparam logic [HP_W-1:0] NOTE_G5 = 7'd40;
  localparam logic [HP_W-1:0] NOTE_C6 = 7'd30;
  localparam logic [HP_W-1:0] NOTE_REST = 7'd0;

  typedef struct packed {
    logic [HP_W-1:0]  hp;
    logic [DUR_W-1:0] dur;
  } entry_t;

  function automatic entry_t song_entry(input int unsigned addr);
    entry_t e;
    e = '0;
    case (addr)
      0:       e = '{hp: 7'd20,     dur: 4'd2};
      1:       e = '{hp: NOTE_REST, dur: 4'd1};
      2:       e = '{hp: 7'd10,     dur: 4'd3};
      default: e = '{hp: NOTE_REST, dur: DUR_END};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/melody_sequencer_if.sv
// Control/status bundle between a song controller and the melody sequencer.
interface melody_sequencer_if #(parameter int ADDR_W = 6);
  logic              start;
  logic              stop;
  logic              loop;
  logic [6:0]        hp;
  logic              active;
  logic              busy;
  logic [ADDR_W-1:0] note_idx;
  logic              done;

  modport master (output start, stop, loop,
                  input  hp, active, busy, note_idx, done);
  modport slave  (input  start, stop, loop,
                  output hp, active, busy, note_idx, done);
endinterface

// File: rtl/melody_sequencer_rom.sv
// Synchronous-read song table: entry for i_addr appears one clock later.
module melody_sequencer_rom
  import melody_sequencer_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] i_addr,
  output entry_t            o_entry
);

  entry_t r_entry;

  always_ff @(posedge clk) begin
    r_entry <= song_entry(32'(i_addr));
  end

  assign o_entry = r_entry;

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM and drives half-period code and gate for freq_synth.
//   state | meaning
//   IDLE  | outputs off, waiting for start
//   LOAD  | ROM address = note_idx
//   FETCH | ROM entry valid; decode note or end marker
//   PLAY  | note sounding for dur tempo ticks
//   GAP   | silence for GAP_TICKS ticks, hp held
//   DONE  | one-cycle done pulse, then IDLE
module melody_sequencer
  import melody_sequencer_pkg::*;
#(
  parameter int TICK_DIV  = 1000,
  parameter int GAP_TICKS = 1,
  parameter int ADDR_W    = 6
) (
  input  logic               synth_clk,
  input  logic               rst,
  melody_sequencer_if.slave  bus
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0]    GAP_LD    = 8'(GAP_TICKS);

  logic [2:0]        r_state;
  logic [TW-1:0]     r_tick_cnt;
  logic [7:0]        r_cnt;
  logic [HP_W-1:0]   r_hp;
  logic              r_active;
  logic              r_done;
  logic [ADDR_W-1:0] r_note_idx;
  logic              w_tick;
  entry_t            w_entry;

  melody_sequencer_rom #(.ADDR_W(ADDR_W)) u_rom (
    .clk     (synth_clk),
    .i_addr  (r_note_idx),
    .o_entry (w_entry)
  );

  assign w_tick = (r_tick_cnt == TICK_LAST);

  always_ff @(posedge synth_clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_cnt      <= '0;
      r_hp       <= '0;
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_note_idx <= '0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_PLAY || r_state == S_GAP)
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
      if (bus.stop) begin
        r_state    <= S_IDLE;
        r_hp       <= '0;
        r_active   <= 1'b0;
        r_tick_cnt <= '0;
      end else begin
        case (r_state)
          S_IDLE: if (bus.start) begin
            r_state    <= S_LOAD;
            r_note_idx <= '0;
          end
          S_LOAD: r_state <= S_FETCH;
          S_FETCH: begin
            if (w_entry.dur == DUR_END) begin
              if (bus.loop) begin
                r_note_idx <= '0;
                r_state    <= S_LOAD;
              end else begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end
            end else begin
              r_hp       <= w_entry.hp;
              r_active   <= (w_entry.hp != '0);
              r_cnt      <= 8'(w_entry.dur);
              r_tick_cnt <= '0;
              r_state    <= S_PLAY;
            end
          end
          S_PLAY: if (w_tick) begin
            if (r_cnt == 8'd1) begin
              r_active <= 1'b0;
              if (GAP_TICKS > 0) begin
                r_cnt   <= GAP_LD;
                r_state <= S_GAP;
              end else begin
                r_note_idx <= r_note_idx + 1'b1;
                r_state    <= S_LOAD;
              end
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_GAP: if (w_tick) begin
            if (r_cnt == 8'd1) begin
              r_note_idx <= r_note_idx + 1'b1;
              r_state    <= S_LOAD;
            end else begin
              r_cnt <= r_cnt - 8'd1;
            end
          end
          S_DONE: begin
            r_hp    <= '0;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.hp       = r_hp;
  assign bus.active   = r_active;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.note_idx = r_note_idx;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench: one-shot, loop, stop, start/stop interplay, reset, and a legato build.
module tb_melody_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  melody_sequencer_if #(.ADDR_W(6)) bus_a ();
  melody_sequencer_if #(.ADDR_W(6)) bus_b ();

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(1), .ADDR_W(6)) dut_a (
    .synth_clk (clk),
    .rst       (rst),
    .bus       (bus_a)
  );

  melody_sequencer #(.TICK_DIV(4), .GAP_TICKS(0), .ADDR_W(6)) dut_b (
    .synth_clk (clk),
    .rst       (rst),
    .bus       (bus_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int b, input int d, input int a, input int hp);
    return 32'((b << 9) | (d << 8) | (a << 7) | hp);
  endfunction

  function automatic logic [31:0] obs(input bit sel);
    if (sel) return {22'b0, bus_b.busy, bus_b.done, bus_b.active, bus_b.hp};
    return {22'b0, bus_a.busy, bus_a.done, bus_a.active, bus_a.hp};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic run_segs(input string tag, input bit sel, input int lens[8],
                          input logic [31:0] words[8]);
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < lens[s]; i++) begin
        step();
        chk($sformatf("%s[%0d.%0d]", tag, s, i), obs(sel), words[s]);
      end
  endtask

  task automatic stop_a();
    bus_a.stop = 1'b1;
    step();
    bus_a.stop = 1'b0;
    bus_a.loop = 1'b0;
  endtask

  initial begin
    int              lens[8];
    logic [31:0]     words[8];
    int              done_cnt;
    int              bad;

    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.loop = 1'b0;
    #12;
    chk("reset_outs", obs(0), mk(0, 0, 0, 0));
    chk("reset_idx", 32'(bus_a.note_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // one-shot song
    lens  = '{2, 8, 6, 10, 12, 6, 1, 1};
    words = '{mk(1,0,0,0), mk(1,0,1,20), mk(1,0,0,20), mk(1,0,0,0),
              mk(1,0,1,10), mk(1,0,0,10), mk(1,1,0,10), mk(0,0,0,0)};
    bus_a.start = 1'b1;
    run_segs("oneshot", 0, lens, words);

    // loop over three passes: no done, A returns every 44 cycles
    bus_a.loop  = 1'b1;
    bus_a.start = 1'b1;
    done_cnt = 0;
    for (int c = 1; c <= 140; c++) begin
      step();
      done_cnt += int'(bus_a.done);
      if (c == 3 || c == 47 || c == 91)
        chk($sformatf("loop_a@%0d", c), {obs(0)[31:0]} | 32'(bus_a.note_idx) << 16,
            mk(1, 0, 1, 20));
      if (c == 44) chk("loop_idx_end", 32'(bus_a.note_idx), 32'd3);
      if (c == 45) chk("loop_idx_wrap", 32'(bus_a.note_idx), 32'd0);
    end
    chk("loop_no_done", 32'(done_cnt), 32'd0);
    stop_a();
    chk("loop_stopped", obs(0), mk(0, 0, 0, 0));

    // stop during note B
    bus_a.start = 1'b1;
    for (int c = 1; c <= 30; c++) step();
    chk("stop_pre", obs(0), mk(1, 0, 1, 10));
    stop_a();
    chk("stop_outs", obs(0), mk(0, 0, 0, 0));
    done_cnt = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      done_cnt += int'(bus_a.done);
    end
    chk("stop_no_done", 32'(done_cnt), 32'd0);
    bus_a.start = 1'b1;
    for (int c = 1; c <= 3; c++) step();
    chk("restart_a", obs(0), mk(1, 0, 1, 20));
    chk("restart_idx", 32'(bus_a.note_idx), 32'd0);
    stop_a();

    // start and stop together from idle
    bus_a.start = 1'b1;
    bus_a.stop  = 1'b1;
    step();
    bus_a.stop = 1'b0;
    chk("startstop_idle", obs(0), mk(0, 0, 0, 0));
    for (int c = 0; c < 5; c++) step();
    chk("startstop_still", obs(0), mk(0, 0, 0, 0));

    // start while busy is ignored
    bus_a.start = 1'b1;
    for (int c = 1; c <= 46; c++) begin
      step();
      if (c == 5) bus_a.start = 1'b1;
      if (c == 17) begin
        chk("busy_rest", obs(0), mk(1, 0, 0, 0));
        chk("busy_rest_idx", 32'(bus_a.note_idx), 32'd1);
      end
      if (c == 27) begin
        chk("busy_b", obs(0), mk(1, 0, 1, 10));
        chk("busy_b_idx", 32'(bus_a.note_idx), 32'd2);
      end
      if (c == 45) chk("busy_done", obs(0), mk(1, 1, 0, 10));
    end
    chk("busy_idle", obs(0), mk(0, 0, 0, 0));

    // legato build
    lens  = '{2, 8, 2, 6, 12, 2, 1, 1};
    words = '{mk(1,0,0,0), mk(1,0,1,20), mk(1,0,0,20), mk(1,0,0,0),
              mk(1,0,1,10), mk(1,0,0,10), mk(1,1,0,10), mk(0,0,0,0)};
    bus_b.start = 1'b1;
    run_segs("legato", 1, lens, words);

    // async reset mid-note, then long idle
    bus_a.start = 1'b1;
    for (int c = 1; c <= 5; c++) step();
    chk("rst_pre", obs(0), mk(1, 0, 1, 20));
    #2 rst = 1'b1;
    #1 chk("rst_async", obs(0), mk(0, 0, 0, 0));
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (obs(0) != 32'd0) bad++;
    end
    chk("rst_idle100", 32'(bad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
